// File: rtl/pwm_bank_if.sv
// Channel compare-value write port for pwm_bank: one strobe carries channel, ON/OFF words and commit mode.
interface pwm_bank_if #(
  parameter int CH_W  = 4,
  parameter int CNT_W = 12
);
  logic             wr_en_i;
  logic [CH_W-1:0]  wr_ch_i;
  logic [CNT_W:0]   wr_on_i;
  logic [CNT_W:0]   wr_off_i;
  logic             commit_mode_i;

  modport master (output wr_en_i, wr_ch_i, wr_on_i, wr_off_i, commit_mode_i);
  modport slave  (input  wr_en_i, wr_ch_i, wr_on_i, wr_off_i, commit_mode_i);
endinterface

// File: rtl/pwm_bank.sv
// Bank of NUM_CH PWM channels sharing one prescaled period counter; per-channel staged/active ON-OFF pairs
// with wrap-synchronous or immediate commit. pwm_o lags counter_o by one clock.
module pwm_bank #(
  parameter int NUM_CH = 16,
  parameter int CNT_W  = 12,
  parameter int PRE_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic [PRE_W-1:0]  prescale_i,
  pwm_bank_if.slave         wr_if,
  input  logic              invert_i,
  input  logic              out_en_i,
  input  logic              idle_level_i,
  output logic [NUM_CH-1:0] pwm_o,
  output logic [CNT_W-1:0]  counter_o,
  output logic              tick_o,
  output logic              pending_o
);
  localparam logic [CNT_W:0] RST_OFF = {1'b1, {CNT_W{1'b0}}};

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tick_q, pending_q, pending_d;
  logic              step, wrap;
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] lvl;
  logic [CNT_W:0]    stg_on_q  [NUM_CH];
  logic [CNT_W:0]    stg_off_q [NUM_CH];
  logic [CNT_W:0]    act_on_q  [NUM_CH];
  logic [CNT_W:0]    act_off_q [NUM_CH];
  logic [CNT_W:0]    stg_on_d  [NUM_CH];
  logic [CNT_W:0]    stg_off_d [NUM_CH];
  logic [CNT_W:0]    act_on_d  [NUM_CH];
  logic [CNT_W:0]    act_off_d [NUM_CH];
  logic              wr_hit;
  int                wr_idx;

  always_comb begin
    pre_d = pre_q;
    step  = 1'b0;
    if (!enable_i) begin
      pre_d = '0;
    end else if (pre_q == prescale_i) begin
      pre_d = '0;
      step  = 1'b1;
    end else begin
      pre_d = pre_q + 1'b1;
    end
    cnt_d = step ? cnt_q + 1'b1 : cnt_q;
    wrap  = step && (cnt_q == {CNT_W{1'b1}});
  end

  assign wr_idx = int'(wr_if.wr_ch_i);
  assign wr_hit = wr_if.wr_en_i && (wr_idx < NUM_CH);

  // Commit runs before the write so a mode-0 write on the wrap edge stays pending for a full period.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      stg_on_d[i]  = stg_on_q[i];
      stg_off_d[i] = stg_off_q[i];
      act_on_d[i]  = act_on_q[i];
      act_off_d[i] = act_off_q[i];
      pend_d[i]    = pend_q[i];
      if (wrap && pend_q[i]) begin
        act_on_d[i]  = stg_on_q[i];
        act_off_d[i] = stg_off_q[i];
        pend_d[i]    = 1'b0;
      end
      if (wr_hit && (wr_idx == i)) begin
        stg_on_d[i]  = wr_if.wr_on_i;
        stg_off_d[i] = wr_if.wr_off_i;
        if (wr_if.commit_mode_i) begin
          act_on_d[i]  = wr_if.wr_on_i;
          act_off_d[i] = wr_if.wr_off_i;
          pend_d[i]    = 1'b0;
        end else begin
          pend_d[i]    = 1'b1;
        end
      end
    end
    pending_d = |pend_d;
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      lvl[i] = 1'b0;
      if (act_off_q[i][CNT_W]) begin
        lvl[i] = 1'b0;
      end else if (act_on_q[i][CNT_W]) begin
        lvl[i] = 1'b1;
      end else if (act_on_q[i][CNT_W-1:0] < act_off_q[i][CNT_W-1:0]) begin
        lvl[i] = (cnt_q >= act_on_q[i][CNT_W-1:0]) && (cnt_q < act_off_q[i][CNT_W-1:0]);
      end else if (act_on_q[i][CNT_W-1:0] > act_off_q[i][CNT_W-1:0]) begin
        lvl[i] = (cnt_q >= act_on_q[i][CNT_W-1:0]) || (cnt_q < act_off_q[i][CNT_W-1:0]);
      end
      pwm_d[i] = out_en_i ? (lvl[i] ^ invert_i) : idle_level_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pre_q     <= '0;
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      pending_q <= 1'b0;
      pwm_q     <= '0;
      pend_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        stg_on_q[i]  <= '0;
        stg_off_q[i] <= RST_OFF;
        act_on_q[i]  <= '0;
        act_off_q[i] <= RST_OFF;
      end
    end else begin
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      tick_q    <= wrap;
      pending_q <= pending_d;
      pwm_q     <= pwm_d;
      pend_q    <= pend_d;
      for (int i = 0; i < NUM_CH; i++) begin
        stg_on_q[i]  <= stg_on_d[i];
        stg_off_q[i] <= stg_off_d[i];
        act_on_q[i]  <= act_on_d[i];
        act_off_q[i] <= act_off_d[i];
      end
    end
  end

  assign pwm_o     = pwm_q;
  assign counter_o = cnt_q;
  assign tick_o    = tick_q;
  assign pending_o = pending_q;
endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank at NUM_CH=4, CNT_W=4, PRE_W=4; waveforms are compared as 16-bit masks indexed by counter_o.
module tb_pwm_bank;
  logic       clk = 1'b0;
  logic       rst;
  logic       enable, invert, out_en, idle;
  logic [3:0] prescale;
  logic [3:0] pwm, counter;
  logic       tick, pending;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  pwm_bank_if #(.CH_W(2), .CNT_W(4)) wr_if ();

  pwm_bank #(.NUM_CH(4), .CNT_W(4), .PRE_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .prescale_i(prescale),
    .wr_if(wr_if), .invert_i(invert), .out_en_i(out_en), .idle_level_i(idle),
    .pwm_o(pwm), .counter_o(counter), .tick_o(tick), .pending_o(pending)
  );

  typedef struct {
    int         ch;
    logic [4:0] on;
    logic [4:0] off;
    logic       inv;
    logic [15:0] exp;
  } vec_t;
  vec_t vt [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  task automatic wr(input int ch, input logic [4:0] on, input logic [4:0] off, input logic mode);
    wr_if.wr_ch_i       = 2'(ch);
    wr_if.wr_on_i       = on;
    wr_if.wr_off_i      = off;
    wr_if.commit_mode_i = mode;
    wr_if.wr_en_i       = 1'b1;
    @(negedge clk);
    wr_if.wr_en_i       = 1'b0;
  endtask

  task automatic wait_cnt(input logic [3:0] val);
    int n = 0;
    while (counter !== val && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (counter !== val) timeout_fail("wait_cnt");
  endtask

  // Starts at the next counter_o==0 (possibly the current cycle) and samples one full period.
  task automatic measure(input int ch, output logic [15:0] m, output int pend_n);
    m = '0;
    pend_n = 0;
    wait_cnt(4'd0);
    for (int k = 0; k < 16; k++) begin
      m[counter] = pwm[ch];
      if (pending) pend_n++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [15:0] m;
    int pn, err, ticks, chg, n;
    logic [3:0] expc, prev;

    vt[0] = '{0, 5'd2,  5'd6,  1'b0, 16'h0078};
    vt[1] = '{0, 5'd2,  5'd6,  1'b1, 16'hFF87};
    vt[2] = '{1, 5'd12, 5'd3,  1'b0, 16'hE00F};
    vt[3] = '{1, 5'd5,  5'd5,  1'b0, 16'h0000};
    vt[4] = '{1, 5'd0,  5'd15, 1'b0, 16'hFFFE};
    vt[5] = '{1, 5'd15, 5'd0,  1'b0, 16'h0001};
    vt[6] = '{3, 5'h1F, 5'h10, 1'b0, 16'h0000};
    vt[7] = '{3, 5'h10, 5'h03, 1'b0, 16'hFFFF};

    rst = 1'b1; enable = 1'b1; invert = 1'b0; out_en = 1'b1; idle = 1'b0; prescale = 4'd0;
    wr_if.wr_en_i = 1'b0; wr_if.wr_ch_i = '0; wr_if.wr_on_i = '0; wr_if.wr_off_i = '0;
    wr_if.commit_mode_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_counter", 32'(counter), 0);
    check("rst_tick", 32'(tick), 0);
    check("rst_pending", 32'(pending), 0);
    check("rst_pwm", 32'(pwm), 0);

    rst = 1'b0;
    err = 0; ticks = 0; expc = 4'd0;
    for (int i = 0; i <= 32; i++) begin
      if (counter !== expc) err++;
      if (tick !== ((expc == 4'd0) && (i > 0))) err++;
      if (tick === 1'b1) ticks++;
      if (pwm !== 4'd0) err++;
      expc = expc + 4'd1;
      @(negedge clk);
    end
    check("count_seq_errors", 32'(err), 0);
    check("tick_count", 32'(ticks), 2);

    for (int v = 0; v < 8; v++) begin
      invert = vt[v].inv;
      wr(vt[v].ch, vt[v].on, vt[v].off, 1'b1);
      @(negedge clk);
      measure(vt[v].ch, m, pn);
      check($sformatf("vec%0d_mask", v), 32'(m), 32'(vt[v].exp));
    end
    invert = 1'b0;

    wait_cnt(4'd5);
    wr(2, 5'd8, 5'd12, 1'b0);
    err = 0; n = 0;
    while (counter !== 4'd0 && n < 40) begin
      if (pending !== 1'b1 || pwm[2] !== 1'b0) err++;
      @(negedge clk);
      n++;
    end
    if (counter !== 4'd0) timeout_fail("m0_wait_wrap");
    check("m0_hold_errors", 32'(err), 0);
    check("m0_pending_cleared", 32'(pending), 0);
    check("m0_tick_at_commit", 32'(tick), 1);
    measure(2, m, pn);
    check("m0_new_mask", 32'(m), 32'h1E00);

    wait_cnt(4'd15);
    wr(2, 5'd0, 5'd4, 1'b0);
    check("wrapwr_pending", 32'(pending), 1);
    measure(2, m, pn);
    check("wrapwr_old_mask", 32'(m), 32'h1E00);
    check("wrapwr_pending_cycles", 32'(pn), 16);
    check("wrapwr_pending_after", 32'(pending), 0);
    measure(2, m, pn);
    check("wrapwr_new_mask", 32'(m), 32'h001E);

    prescale = 4'd2;
    prev = counter; chg = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (counter !== prev) chg++;
      prev = counter;
    end
    check("prescale2_steps", 32'(chg), 10);
    prescale = 4'd0;

    enable = 1'b0;
    @(negedge clk);
    prev = counter; chg = 0; ticks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (counter !== prev) chg++;
      if (tick === 1'b1) ticks++;
    end
    check("sleep_changes", 32'(chg), 0);
    check("sleep_ticks", 32'(ticks), 0);
    enable = 1'b1;

    out_en = 1'b0; idle = 1'b1;
    @(negedge clk);
    check("idle_high", 32'(pwm), 32'hF);
    invert = 1'b1; idle = 1'b0;
    @(negedge clk);
    check("idle_low_not_inverted", 32'(pwm), 0);
    out_en = 1'b1; invert = 1'b0;
    @(negedge clk);

    wait_cnt(4'd5);
    wr(3, 5'd0, 5'd8, 1'b0);
    check("rstp_pending", 32'(pending), 1);
    wait_cnt(4'd9);
    rst = 1'b1;
    #1;
    check("rstp_counter", 32'(counter), 0);
    check("rstp_pwm", 32'(pwm), 0);
    check("rstp_pending_cleared", 32'(pending), 0);
    check("rstp_tick", 32'(tick), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rstp_release_counter", 32'(counter), 0);
    @(negedge clk);
    check("rstp_resume_counter", 32'(counter), 1);
    measure(3, m, pn);
    check("rstp_ch3_mask", 32'(m), 0);
    check("rstp_pending_cycles", 32'(pn), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pwm_bank.md
PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 Parameter NUM_CH, default 16, number of PWM channels (1..64).
REQ-002 Parameter CNT_W, default 12, width of the period counter and of the ON/OFF compare values.
REQ-003 Parameter PRE_W, default 8, width of the prescale value.
REQ-004 clk_i  in  1  single clock for all logic.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 enable_i  in  1  1 = counter runs; 0 = counter frozen (sleep).
REQ-007 prescale_i  in  PRE_W  counter advances once every prescale_i+1 clocks.
REQ-008 wr_en_i  in  1  one-cycle write strobe for channel compare values.
REQ-009 wr_ch_i  in  $clog2(NUM_CH) (min 1)  target channel index.
REQ-010 wr_on_i  in  CNT_W+1  ON count; MSB = full-on flag.
REQ-011 wr_off_i  in  CNT_W+1  OFF count; MSB = full-off flag.
REQ-012 commit_mode_i  in  1  0 = commit at period wrap; 1 = commit immediately.
REQ-013 invert_i  in  1  invert all channel outputs.
REQ-014 out_en_i  in  1  1 = drive PWM; 0 = drive idle_level_i on all channels.
REQ-015 idle_level_i  in  1  level driven while out_en_i = 0.
REQ-016 pwm_o  out  NUM_CH  registered channel outputs.
REQ-017 counter_o  out  CNT_W  current period counter.
REQ-018 tick_o  out  1  one-cycle pulse, period wrap.
REQ-019 pending_o  out  1  1 while any staged value awaits commit.

Function
REQ-020 Prescaler: counts 0..prescale_i while enable_i = 1; on reaching prescale_i it clears and generates a step; prescale_i = 0 steps every clock.
REQ-021 enable_i = 0 clears the prescaler and holds counter_o; no steps and no ticks occur.
REQ-022 Each step increments counter_o modulo 2^CNT_W; the step from 2^CNT_W-1 to 0 is the wrap.
REQ-023 tick_o is 1 for exactly the clock following the wrap edge (the first cycle in which counter_o = 0 after a wrap).
REQ-024 Each channel holds a staging pair (on, off) and an active pair; pwm_o uses only the active pair.
REQ-025 A write with wr_ch_i >= NUM_CH is ignored with no state change.
REQ-026 Mode 1: the write updates both staging and active pairs on the same edge; the new value is visible on pwm_o 1 clock later.
REQ-027 Mode 0: the write updates staging only and sets that channel's pending flag; at the wrap edge every pending channel copies staging to active and clears its flag.
REQ-028 Mode 0 write on the same edge as the wrap: the write lands in staging, the pre-edge staging contents commit, and the new value stays pending until the next wrap.
REQ-029 pending_o = OR of all pending flags, registered; a mode-1 write clears that channel's pending flag.
REQ-030 Per-channel level, evaluated on counter_o: full-off flag set -> 0 (overrides full-on); else full-on -> 1; else on == off -> 0; else on < off -> high when on <= cnt < off; else on > off -> high when cnt >= on or cnt < off.
REQ-031 Final level: out_en_i = 0 -> idle_level_i (not inverted); else level XOR invert_i; registered into pwm_o with 1-clock latency from counter_o.
REQ-032 Compare values are unsigned CNT_W-bit; flag bits take no part in the compare.

Reset
REQ-033 While rst_i = 1, asynchronously: prescaler = 0, counter_o = 0, tick_o = 0, pending_o = 0, pwm_o = 0, all pending flags = 0.
REQ-034 All staging and active pairs reset to on = 0 and off = full-off flag set, compare value 0 (channel off).
REQ-035 Reset asserted mid-period or mid-pending discards all staged values; operation resumes from counter 0 on the first clock after release.

Verification (NUM_CH=4, CNT_W=4, PRE_W=4)
REQ-036 Reset release, enable=1, prescale=0 -> counter_o counts 0..15 and repeats; tick_o is high once per 16 clocks, in the cycle where counter_o = 0; pwm_o = 0.
REQ-037 Mode 1, ch0 on=2 off=6 -> pwm_o[0] high for exactly 4 clocks per period, rising 1 clock after counter_o = 2; invert=1 gives the complement.
REQ-038 Mode 1, ch1 on=12 off=3 -> pwm_o[1] high for 7 clocks, spanning the wrap (counts 12..15, 0..2).
REQ-039 Mode 0, write ch2 at counter 5 -> pending_o=1 and pwm_o[2] unchanged until the wrap edge; new waveform from counter 0; pending_o=0 after. Repeat the write exactly on the wrap edge -> commit deferred one full period.
REQ-040 ch3 full-on+full-off -> 0; full-on only -> constant 1; prescale=2 -> counter steps every 3 clocks; out_en=0, idle_level=1 -> all pwm_o = 1 one clock later.
REQ-041 rst_i pulsed at counter 9 with a pending write -> all outputs at reset values immediately; the pending value is never applied.
